// File: rtl/cp0_regfile_if.sv
// Bundle of CP0 register-file traffic: MTC0 writes, MFC0 reads, exception/ERET
// commits, interrupt lines and the published Status/Cause/EPC values.
interface cp0_regfile_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  we;
    logic [4:0]            waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [4:0]            raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic [5:0]            int_i;
    logic                  exc_valid;
    logic [4:0]            exc_code;
    logic [DATA_WIDTH-1:0] exc_pc;
    logic                  exc_in_delay_slot;
    logic                  eret;
    logic [DATA_WIDTH-1:0] status;
    logic [DATA_WIDTH-1:0] cause;
    logic [DATA_WIDTH-1:0] epc;
    logic                  timer_int;

    modport master (
        output we, waddr, wdata, raddr, int_i,
        output exc_valid, exc_code, exc_pc, exc_in_delay_slot, eret,
        input  rdata, status, cause, epc, timer_int
    );

    modport slave (
        input  we, waddr, wdata, raddr, int_i,
        input  exc_valid, exc_code, exc_pc, exc_in_delay_slot, eret,
        output rdata, status, cause, epc, timer_int
    );
endinterface

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC, PRId,
// with exception and ERET commit handling.
module cp0_regfile #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PRID_VALUE = 32'h0001_8000
) (
    input logic            clk,
    input logic            rst_n,
    cp0_regfile_if.slave   bus
);
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam logic [DATA_WIDTH-1:0] STATUS_RESET = DATA_WIDTH'(32'h1000_0000);

    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] compare_q;
    logic [DATA_WIDTH-1:0] status_q;
    logic [DATA_WIDTH-1:0] cause_q;
    logic [DATA_WIDTH-1:0] epc_q;
    logic                  timer_q;

    logic [DATA_WIDTH-1:0] status_next;
    logic [DATA_WIDTH-1:0] cause_next;
    logic [DATA_WIDTH-1:0] epc_next;

    logic mtc0;
    logic wr_count;
    logic wr_compare;
    logic wr_status;
    logic wr_cause;
    logic wr_epc;
    logic exl;
    logic timer_match;

    // An exception squashes the MTC0 retiring alongside it.
    assign mtc0        = bus.we & ~bus.exc_valid;
    assign wr_count    = mtc0 && (bus.waddr == REG_COUNT);
    assign wr_compare  = mtc0 && (bus.waddr == REG_COMPARE);
    assign wr_status   = mtc0 && (bus.waddr == REG_STATUS);
    assign wr_cause    = mtc0 && (bus.waddr == REG_CAUSE);
    assign wr_epc      = mtc0 && (bus.waddr == REG_EPC);
    assign exl         = status_q[1];
    assign timer_match = (count_q == compare_q) && (compare_q != '0);

    always_comb begin
        status_next = status_q;
        if (wr_status) begin
            status_next = bus.wdata;
        end
        if (bus.exc_valid) begin
            status_next[1] = 1'b1;
        end else if (bus.eret) begin
            status_next[1] = 1'b0;
        end
    end

    always_comb begin
        cause_next        = cause_q;
        cause_next[15:10] = {bus.int_i[5] | timer_q, bus.int_i[4:0]};
        if (wr_cause) begin
            cause_next[9:8]   = bus.wdata[9:8];
            cause_next[23:22] = bus.wdata[23:22];
        end
        if (bus.exc_valid) begin
            cause_next[6:2] = bus.exc_code;
            if (!exl) begin
                cause_next[31] = bus.exc_in_delay_slot;
            end
        end
    end

    // Nested exceptions (EXL already set) keep the original return address.
    always_comb begin
        epc_next = epc_q;
        if (bus.exc_valid) begin
            if (!exl) begin
                epc_next = bus.exc_in_delay_slot ? (bus.exc_pc - DATA_WIDTH'(4))
                                                 : bus.exc_pc;
            end
        end else if (wr_epc) begin
            epc_next = bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= '0;
            status_q  <= STATUS_RESET;
            cause_q   <= '0;
            epc_q     <= '0;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= wr_count ? bus.wdata : count_q + DATA_WIDTH'(1);
            compare_q <= wr_compare ? bus.wdata : compare_q;
            if (wr_compare) begin
                timer_q <= 1'b0;
            end else if (timer_match) begin
                timer_q <= 1'b1;
            end
            status_q  <= status_next;
            cause_q   <= cause_next;
            epc_q     <= epc_next;
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.raddr)
            REG_COUNT:   bus.rdata = count_q;
            REG_COMPARE: bus.rdata = compare_q;
            REG_STATUS:  bus.rdata = status_q;
            REG_CAUSE:   bus.rdata = cause_q;
            REG_EPC:     bus.rdata = epc_q;
            REG_PRID:    bus.rdata = PRID_VALUE;
            default:     bus.rdata = '0;
        endcase
    end

    assign bus.status    = status_q;
    assign bus.cause     = cause_q;
    assign bus.epc       = epc_q;
    assign bus.timer_int = timer_q;
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file, the write/commit end of the CP0 path.
- Holds Count, Compare, Status, Cause, EPC and PRId.
- Accepts MTC0 writes from writeback, exception/ERET commits from the exception handler, and hardware interrupt lines.
- Publishes current Status/Cause/EPC to the memory-access stage, which applies its own writeback forwarding on top; also serves the MFC0 read port and raises the timer interrupt.

Parameters:
DATA_WIDTH, 32, width of every CP0 register and data port
PRID_VALUE, 32'h0001_8000, constant returned for PRId reads

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset; synchronous, active-low
we  input  1  MTC0 write enable from writeback
waddr  input  5  CP0 write register number
wdata  input  DATA_WIDTH  MTC0 write data
raddr  input  5  MFC0 read register number
rdata  output  DATA_WIDTH  MFC0 read data, combinational
int_i  input  6  hardware interrupt lines, level-sensitive
exc_valid  input  1  exception commit this cycle
exc_code  input  5  ExcCode for Cause[6:2]
exc_pc  input  DATA_WIDTH  PC of faulting instruction
exc_in_delay_slot  input  1  faulting instruction is in a branch delay slot
eret  input  1  ERET commit this cycle
status  output  DATA_WIDTH  current Status
cause  output  DATA_WIDTH  current Cause
epc  output  DATA_WIDTH  current EPC
timer_int  output  1  sticky timer interrupt

Behaviour:
Register numbers and reset values (synchronous, on a clk edge with rst_n=0):
- Count=9, reset 0
- Compare=11, reset 0
- Status=12, reset 32'h1000_0000
- Cause=13, reset 0
- EPC=14, reset 0
- PRId=15, read-only
- timer_int resets to 0.
- All other state is cleared on reset; reset asserted mid-operation overrides every other input that cycle.

Read port:
- rdata is a pure mux of the register current values.
- PRId returns PRID_VALUE; unimplemented numbers return 0.
- No write-to-read bypass inside this block; forwarding belongs to the memory-access stage.
- status, cause and epc are driven directly from their registers.

Count:
- Increments by 1 every cycle; wraps 32'hFFFF_FFFF -> 0.
- MTC0 to Count loads wdata; no increment that cycle.

Compare and timer_int:
- MTC0 to Compare loads wdata and clears timer_int.
- Otherwise timer_int sets (sticky) on any cycle with Count == Compare and Compare != 0; evaluated on the pre-increment Count value.
- Compare write and match in the same cycle: the clear wins.

Cause:
- Cause[15:10] <= int_i every cycle; Cause[15] is ORed with timer_int (value registered one cycle later).
- MTC0 to Cause updates only bits 9:8 (software interrupts), 22 (WP) and 23 (IV); all other bits are unchanged.

Status:
- MTC0 writes all 32 bits.

Exception commit (exc_valid=1):
- If Status[1] (EXL) = 0:
  - EPC <= exc_in_delay_slot ? exc_pc-4 : exc_pc
  - Cause[31] (BD) <= exc_in_delay_slot
- If EXL = 1: EPC and BD are unchanged.
- Always: Cause[6:2] <= exc_code, Status[1] <= 1.
- An MTC0 in the same cycle is discarded entirely (it belongs to a squashed instruction).
- exc_pc-4 is modulo 2^DATA_WIDTH.

ERET commit (eret=1, exc_valid=0):
- Status[1] <= 0.
- A same-cycle MTC0 applies, except that the write to Status bit 1 is overridden by ERET.

Priority per cycle:
- reset > exc_valid > eret > we.
- Hardware interrupt sampling and Count increment occur regardless of exc_valid/eret.

Latency:
- All writes are visible on outputs and rdata on the cycle after the clk edge.
- No handshakes; every input is a single-cycle pulse or a level.

Test Plan:
- Reset, then 5 cycles idle -> status=32'h1000_0000, cause=0, epc=0; Count read via raddr=9 equals 5; raddr=15 returns 32'h0001_8000; raddr=3 returns 0.
- MTC0 Compare=20 at Count=10 -> timer_int rises on the cycle after Count==20, cause[15]=1 one cycle later; MTC0 Compare=40 -> timer_int=0 the next cycle.
- MTC0 Cause=32'hFFFF_FFFF -> cause=32'h00C0_0300 (with int_i=0, no timer); int_i=6'b000101 -> cause[15:10]=6'b000101 one cycle later.
- exc_valid, exc_code=5'd8, exc_pc=32'h0040_0010, delay slot=1, EXL=0 -> epc=32'h0040_000C, cause[31]=1, cause[6:2]=8, status[1]=1; second exception with exc_pc=32'h0000_1000 -> epc unchanged, cause[6:2] updated.
- exc_valid and MTC0 EPC=32'hDEAD_BEEF in the same cycle -> EPC takes the exception value; eret with MTC0 Status=32'h0000_0003 -> status=32'h0000_0001.
- MTC0 Count=32'hFFFF_FFFE -> reads 32'hFFFF_FFFF, then 0; reset asserted during an exc_valid cycle -> all reset values, EPC=0.
